spi_arb: RTL and testbench

Arbiter and sequencer that shares one SPI transaction engine between the inertial-sensor interface and the A2D interface of the Segway controller. Each requester presents a 16-bit command and holds a request. The arbiter grants one requester at a time, launches the SPI transaction, and returns the 16-bit response with a one-cycle done pulse. The inertial path has priority; a starvation limit guarantees A2D battery, load-cell and steering readings still progress. A watchdog reports a hung transaction instead of locking up the bus.

---
 rtl/spi_arb.sv | 125 ++++++++++++
 tb/tb_spi_arb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arb.sv
// Shares one SPI transaction engine between the inertial and A2D requesters.
// Inertial has priority, A2D is forced after STARVE_LIM inertial wins, and a watchdog ends hung transfers.
module spi_arb #(
    parameter int STARVE_LIM = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inert_req,
    input  logic [15:0] inert_cmd,
    output logic        inert_gnt,
    output logic        inert_done,
    output logic [15:0] inert_resp,
    input  logic        a2d_req,
    input  logic [15:0] a2d_cmd,
    output logic        a2d_gnt,
    output logic        a2d_done,
    output logic [15:0] a2d_resp,
    output logic        err,
    output logic        sel,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_resp
);

    localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIM);
    localparam logic [9:0] WD_LAST    = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  starve_cnt;
    logic [9:0]  wd_cnt;
    logic        pick_a2d;
    logic        launch;
    logic        finish;
    logic        timeout;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        finish     = 1'b0;
        timeout    = 1'b0;
        pick_a2d   = a2d_req && (!inert_req || starve_cnt == STARVE_MAX);
        case (state)
            IDLE: begin
                if (inert_req || a2d_req) begin
                    launch     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = BUSY;
            BUSY: begin
                // A real completion on the last watchdog cycle still wins over the abort.
                if (spi_done) begin
                    finish     = 1'b1;
                    state_next = RESP;
                end else if (wd_cnt == WD_LAST) begin
                    finish     = 1'b1;
                    timeout    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // sel doubles as the owner of the current transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            inert_gnt  <= 1'b0;
            inert_done <= 1'b0;
            inert_resp <= 16'h0000;
            a2d_gnt    <= 1'b0;
            a2d_done   <= 1'b0;
            a2d_resp   <= 16'h0000;
            err        <= 1'b0;
            sel        <= 1'b0;
            spi_wrt    <= 1'b0;
            spi_cmd    <= 16'h0000;
            starve_cnt <= 2'd0;
            wd_cnt     <= 10'd0;
        end else begin
            spi_wrt    <= launch;
            inert_done <= finish && !sel;
            a2d_done   <= finish && sel;
            err        <= timeout;
            wd_cnt     <= (state == BUSY) ? wd_cnt + 10'd1 : 10'd0;

            if (launch) begin
                sel       <= pick_a2d;
                spi_cmd   <= pick_a2d ? a2d_cmd : inert_cmd;
                inert_gnt <= !pick_a2d;
                a2d_gnt   <= pick_a2d;
                if (pick_a2d)
                    starve_cnt <= 2'd0;
                else if (a2d_req && starve_cnt != STARVE_MAX)
                    starve_cnt <= starve_cnt + 2'd1;
            end

            if (state == RESP) begin
                inert_gnt <= 1'b0;
                a2d_gnt   <= 1'b0;
            end

            if (finish) begin
                if (sel)
                    a2d_resp <= timeout ? 16'hFFFF : spi_resp;
                else
                    inert_resp <= timeout ? 16'hFFFF : spi_resp;
            end
        end
    end

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb: priority, starvation, watchdog, reset abort and ignored inputs.
module tb_spi_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        inert_req;
    logic [15:0] inert_cmd;
    logic        inert_gnt;
    logic        inert_done;
    logic [15:0] inert_resp;
    logic        a2d_req;
    logic [15:0] a2d_cmd;
    logic        a2d_gnt;
    logic        a2d_done;
    logic [15:0] a2d_resp;
    logic        err;
    logic        sel;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_resp;

    int checks = 0;
    int errors = 0;

    spi_arb #(.STARVE_LIM(3), .TIMEOUT(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .inert_req  (inert_req),
        .inert_cmd  (inert_cmd),
        .inert_gnt  (inert_gnt),
        .inert_done (inert_done),
        .inert_resp (inert_resp),
        .a2d_req    (a2d_req),
        .a2d_cmd    (a2d_cmd),
        .a2d_gnt    (a2d_gnt),
        .a2d_done   (a2d_done),
        .a2d_resp   (a2d_resp),
        .err        (err),
        .sel        (sel),
        .spi_wrt    (spi_wrt),
        .spi_cmd    (spi_cmd),
        .spi_done   (spi_done),
        .spi_resp   (spi_resp)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Engine completion pulse, driven on a falling edge and lasting one cycle.
    task automatic applyStimulus(input logic [15:0] resp);
        spi_done = 1'b1;
        spi_resp = resp;
        @(negedge clk);
        spi_done = 1'b0;
        spi_resp = 16'h0000;
    endtask

    task automatic waitForWrt(input string tag);
        int n = 0;
        while (spi_wrt !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {15'd0, spi_wrt}, 16'h0001);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_inert_gnt"},  {15'd0, inert_gnt},  16'h0);
        checkOutput({tag, "_a2d_gnt"},    {15'd0, a2d_gnt},    16'h0);
        checkOutput({tag, "_inert_done"}, {15'd0, inert_done}, 16'h0);
        checkOutput({tag, "_a2d_done"},   {15'd0, a2d_done},   16'h0);
        checkOutput({tag, "_err"},        {15'd0, err},        16'h0);
        checkOutput({tag, "_spi_wrt"},    {15'd0, spi_wrt},    16'h0);
        checkOutput({tag, "_sel"},        {15'd0, sel},        16'h0);
        checkOutput({tag, "_spi_cmd"},    spi_cmd,             16'h0);
        checkOutput({tag, "_inert_resp"}, inert_resp,          16'h0);
        checkOutput({tag, "_a2d_resp"},   a2d_resp,            16'h0);
    endtask

    initial begin
        rst       = 1'b1;
        inert_req = 1'b0;
        inert_cmd = 16'h0000;
        a2d_req   = 1'b0;
        a2d_cmd   = 16'h0000;
        spi_done  = 1'b0;
        spi_resp  = 16'h0000;
        tick(2);
        checkAllZero("reset");
        rst = 1'b0;

        // Inertial alone: start one cycle after request, completion one cycle after spi_done.
        inert_cmd = 16'hA255;
        inert_req = 1'b1;
        tick(1);
        checkOutput("inert_wrt_latency", {15'd0, spi_wrt},   16'h1);
        checkOutput("inert_sel",         {15'd0, sel},       16'h0);
        checkOutput("inert_spi_cmd",     spi_cmd,            16'hA255);
        checkOutput("inert_gnt_issue",   {15'd0, inert_gnt}, 16'h1);
        checkOutput("inert_a2d_gnt",     {15'd0, a2d_gnt},   16'h0);
        tick(1);
        checkOutput("inert_wrt_one_cycle", {15'd0, spi_wrt}, 16'h0);
        tick(30);
        checkOutput("inert_no_early_done", {15'd0, inert_done}, 16'h0);
        applyStimulus(16'h1234);
        inert_req = 1'b0;
        checkOutput("inert_done",      {15'd0, inert_done}, 16'h1);
        checkOutput("inert_resp",      inert_resp,          16'h1234);
        checkOutput("inert_gnt_resp",  {15'd0, inert_gnt},  16'h1);
        checkOutput("inert_err",       {15'd0, err},        16'h0);
        checkOutput("inert_a2d_done",  {15'd0, a2d_done},   16'h0);
        checkOutput("inert_a2d_resp",  a2d_resp,            16'h0);
        tick(1);
        checkOutput("inert_done_pulse", {15'd0, inert_done}, 16'h0);
        checkOutput("inert_gnt_idle",   {15'd0, inert_gnt},  16'h0);

        // Both held: inertial, inertial, inertial, A2D, repeated.
        inert_cmd = 16'hA2B7;
        a2d_cmd   = 16'h0800;
        inert_req = 1'b1;
        a2d_req   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic exp_a2d;
            exp_a2d = (i % 4 == 3);
            waitForWrt($sformatf("starve%0d_wrt", i));
            checkOutput($sformatf("starve%0d_a2d_gnt", i),   {15'd0, a2d_gnt},   {15'd0, exp_a2d});
            checkOutput($sformatf("starve%0d_inert_gnt", i), {15'd0, inert_gnt}, {15'd0, !exp_a2d});
            checkOutput($sformatf("starve%0d_sel", i),       {15'd0, sel},       {15'd0, exp_a2d});
            checkOutput($sformatf("starve%0d_spi_cmd", i),   spi_cmd,            exp_a2d ? 16'h0800 : 16'hA2B7);
            tick(2);
            applyStimulus(16'h1000 + 16'(i));
            checkOutput($sformatf("starve%0d_a2d_done", i),   {15'd0, a2d_done},   {15'd0, exp_a2d});
            checkOutput($sformatf("starve%0d_inert_done", i), {15'd0, inert_done}, {15'd0, !exp_a2d});
            checkOutput($sformatf("starve%0d_sel_hold", i),   {15'd0, sel},        {15'd0, exp_a2d});
            checkOutput($sformatf("starve%0d_resp", i), exp_a2d ? a2d_resp : inert_resp, 16'h1000 + 16'(i));
        end
        inert_req = 1'b0;
        a2d_req   = 1'b0;
        tick(2);

        // Hung engine: done and err together 1024 cycles after ISSUE ends.
        inert_cmd = 16'hA2C3;
        inert_req = 1'b1;
        waitForWrt("hang_wrt");
        tick(1024);
        checkOutput("hang_no_early_done", {15'd0, inert_done}, 16'h0);
        tick(1);
        inert_req = 1'b0;
        checkOutput("hang_done", {15'd0, inert_done}, 16'h1);
        checkOutput("hang_err",  {15'd0, err},        16'h1);
        checkOutput("hang_resp", inert_resp,          16'hFFFF);
        tick(1);
        checkOutput("hang_err_pulse", {15'd0, err}, 16'h0);
        a2d_cmd = 16'h0800;
        a2d_req = 1'b1;
        waitForWrt("post_hang_wrt");
        checkOutput("post_hang_a2d_gnt", {15'd0, a2d_gnt}, 16'h1);
        checkOutput("post_hang_sel",     {15'd0, sel},     16'h1);
        tick(2);
        applyStimulus(16'h5A5A);
        a2d_req = 1'b0;
        checkOutput("post_hang_done",       {15'd0, a2d_done}, 16'h1);
        checkOutput("post_hang_err",        {15'd0, err},      16'h0);
        checkOutput("post_hang_resp",       a2d_resp,          16'h5A5A);
        checkOutput("post_hang_inert_resp", inert_resp,        16'hFFFF);
        tick(2);

        // Reset mid-BUSY of an A2D transaction, then a late spi_done.
        a2d_cmd = 16'h0801;
        a2d_req = 1'b1;
        waitForWrt("rst_wrt");
        checkOutput("rst_pre_sel", {15'd0, sel}, 16'h1);
        tick(3);
        a2d_req = 1'b0;
        rst     = 1'b1;
        tick(1);
        checkAllZero("rst_mid");
        rst = 1'b0;
        applyStimulus(16'h7777);
        checkOutput("late_a2d_done",   {15'd0, a2d_done},   16'h0);
        checkOutput("late_inert_done", {15'd0, inert_done}, 16'h0);
        checkOutput("late_a2d_resp",   a2d_resp,            16'h0);
        checkOutput("late_spi_wrt",    {15'd0, spi_wrt},    16'h0);
        tick(2);

        // Requester drops req and changes cmd during BUSY.
        inert_cmd = 16'hA2E5;
        inert_req = 1'b1;
        waitForWrt("drop_wrt");
        checkOutput("drop_spi_cmd", spi_cmd, 16'hA2E5);
        tick(1);
        inert_req = 1'b0;
        inert_cmd = 16'hFFFF;
        tick(2);
        checkOutput("drop_spi_cmd_hold", spi_cmd,            16'hA2E5);
        checkOutput("drop_gnt_hold",     {15'd0, inert_gnt}, 16'h1);
        applyStimulus(16'h0BEE);
        checkOutput("drop_done", {15'd0, inert_done}, 16'h1);
        checkOutput("drop_resp", inert_resp,          16'h0BEE);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput($sformatf("drop_no_wrt%0d", i), {15'd0, spi_wrt},   16'h0);
            checkOutput($sformatf("drop_no_gnt%0d", i), {15'd0, inert_gnt}, 16'h0);
        end

        // Spurious spi_done in IDLE, then prove the FSM still starts in one cycle.
        applyStimulus(16'hDEAD);
        checkOutput("spur_inert_done", {15'd0, inert_done}, 16'h0);
        checkOutput("spur_a2d_done",   {15'd0, a2d_done},   16'h0);
        checkOutput("spur_inert_resp", inert_resp,          16'h0BEE);
        checkOutput("spur_a2d_resp",   a2d_resp,            16'h0);
        checkOutput("spur_spi_wrt",    {15'd0, spi_wrt},    16'h0);
        a2d_cmd = 16'h0802;
        a2d_req = 1'b1;
        tick(1);
        checkOutput("spur_next_wrt", {15'd0, spi_wrt}, 16'h1);
        checkOutput("spur_next_cmd", spi_cmd,          16'h0802);
        checkOutput("spur_next_sel", {15'd0, sel},     16'h1);
        tick(2);
        applyStimulus(16'hC0DE);
        a2d_req = 1'b0;
        checkOutput("spur_next_done", {15'd0, a2d_done}, 16'h1);
        checkOutput("spur_next_resp", a2d_resp,          16'hC0DE);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
